// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler that shares one registered 8-bit ALU between NREQ requesters.
// Latency: accept at T, ISSUE at T+1, CAPTURE at T+2, resp_valid at T+3 at the earliest; at least 4 cycles per operation.
// Backpressure: holds the response stable while resp_ready is low; no new request is accepted until the response handshake.
module alu_sched #(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [8*NREQ-1:0]   req_a,
   input  logic [8*NREQ-1:0]   req_b,
   input  logic [2*NREQ-1:0]   req_op,
   output logic [7:0]          alu_a,
   output logic [7:0]          alu_b,
   output logic [1:0]          alu_op,
   input  logic [7:0]          alu_out,
   input  logic                alu_carry,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [7:0]          resp_data,
   output logic                resp_carry,
   output logic [IDW-1:0]      resp_id,
   output logic                busy,
   output logic [15:0]         done_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t          state_q;
   logic [IDW-1:0]  last_q;
   logic [7:0]      a_q, b_q;
   logic [1:0]      op_q;
   logic [IDW-1:0]  id_q;
   logic            rvld_q;
   logic [7:0]      rdata_q;
   logic            rcarry_q;
   logic [15:0]     done_cnt_q;
   logic [15:0]     done_cnt_d;

   logic            grant_vld;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  cand;
   logic [7:0]      a_d, b_d;
   logic [1:0]      op_d;

   // Round-robin search: walk the ring starting one past the last winner, first valid wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = last_q;
      for (int k = 0; k < NREQ; k++) begin
         cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Payload mux for the winning requester.
   always_comb begin
      a_d  = '0;
      b_d  = '0;
      op_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            a_d  = req_a[8*i +: 8];
            b_d  = req_b[8*i +: 8];
            op_d = req_op[2*i +: 2];
         end
      end
   end

   // Accept strobe only exists in IDLE and is suppressed while reset is asserted.
   always_comb begin
      req_ready = '0;
      if ((state_q == IDLE) && !rst && grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign done_cnt_d = done_cnt_q + 16'd1;

   // Operation sequencer: accept, let the ALU register its result, capture it, then hold the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_q     <= IDW'(NREQ - 1);
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         id_q       <= '0;
         rvld_q     <= 1'b0;
         rdata_q    <= '0;
         rcarry_q   <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  op_q    <= op_d;
                  id_q    <= grant_idx;
                  last_q  <= grant_idx;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               rdata_q  <= alu_out;
               rcarry_q <= alu_carry;
               rvld_q   <= 1'b1;
               state_q  <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  rvld_q     <= 1'b0;
                  done_cnt_q <= done_cnt_d;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign resp_valid = rvld_q;
   assign resp_data  = rdata_q;
   assign resp_carry = rcarry_q;
   assign resp_id    = id_q;
   assign busy       = (state_q != IDLE);
   assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and randomized bench for alu_sched with a transaction-level reference model.
// Latency: model predicts every output each cycle; response expected 3 cycles after accept.
// Backpressure: resp_ready is driven both held-low and randomly.
module tb_alu_sched;
   localparam int N   = 3;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [8*N-1:0]    req_a, req_b;
   logic [2*N-1:0]    req_op;
   logic [7:0]        alu_a, alu_b;
   logic [1:0]        alu_op;
   logic [7:0]        alu_out;
   logic              alu_carry;
   logic              resp_valid, resp_ready;
   logic [7:0]        resp_data;
   logic              resp_carry;
   logic [IDW-1:0]    resp_id;
   logic              busy;
   logic [15:0]       done_cnt;

   always #5 clk = ~clk;

   alu_sched #(.NREQ(N), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_carry(resp_carry), .resp_id(resp_id),
      .busy(busy), .done_cnt(done_cnt)
   );

   // Registered ALU sharing clk/rst with the scheduler.
   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      case (op)
         2'd0:    return {1'b0, a} + {1'b0, b};
         2'd1:    return {1'b0, a} - {1'b0, b};
         2'd2:    return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) {alu_carry, alu_out} <= 9'd0;
      else     {alu_carry, alu_out} <= alu_f(alu_a, alu_b, alu_op);
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model state (transaction level: one operation in flight, age in cycles).
   bit          m_busy;
   int          m_age;
   int          m_last;
   int          m_a, m_b, m_op, m_id;
   int          m_data, m_carry;
   bit          m_fresh;
   logic [15:0] m_cnt;

   // Last sampled DUT outputs.
   logic [N-1:0] s_ready;
   logic         s_valid, s_carry, s_busy;
   logic [7:0]   s_data;
   int           s_id;
   logic [15:0]  s_cnt;
   logic [7:0]   s_a;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic fail_timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s cycle=%0d got=timeout expected=event", nm, cyc);
   endtask

   function automatic void model_reset();
      m_busy = 0; m_age = 0; m_last = N - 1;
      m_a = 0; m_b = 0; m_op = 0; m_id = 0;
      m_data = 0; m_carry = 0; m_fresh = 1; m_cnt = 16'd0;
   endfunction

   function automatic int pick();
      if (rst || m_busy) return -1;
      for (int k = 1; k <= N; k++) begin
         if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
      end
      return -1;
   endfunction

   // Expected result straight from the arithmetic rules.
   function automatic void compute(input int a, input int b, input int op);
      case (op)
         0: begin m_data = (a + b) % 256;       m_carry = (a + b > 255) ? 1 : 0; end
         1: begin m_data = (a - b + 256) % 256; m_carry = (a < b) ? 1 : 0;       end
         2: begin m_data = a & b;               m_carry = 0;                     end
         default: begin m_data = a | b;         m_carry = 0;                     end
      endcase
   endfunction

   // One cycle: sample/compare just after the negedge with inputs applied, advance model over the posedge.
   task automatic step();
      int g;
      logic [N-1:0] er;
      bit ev;
      #1;
      cyc++;
      g = pick();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ev = m_busy && (m_age >= 3);
      s_ready = req_ready; s_valid = resp_valid; s_data = resp_data; s_carry = resp_carry;
      s_id = int'(resp_id); s_cnt = done_cnt; s_busy = busy; s_a = alu_a;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_op", 32'(alu_op), 32'(m_op));
      if (ev || m_fresh) begin
         chk("resp_data", 32'(resp_data), m_fresh ? 32'd0 : 32'(m_data));
         chk("resp_carry", 32'(resp_carry), m_fresh ? 32'd0 : 32'(m_carry));
         chk("resp_id", 32'(resp_id), m_fresh ? 32'd0 : 32'(m_id));
      end
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         if (g >= 0) begin
            m_a = int'(req_a[8*g +: 8]);
            m_b = int'(req_b[8*g +: 8]);
            m_op = int'(req_op[2*g +: 2]);
            m_id = g; m_last = g; m_busy = 1; m_age = 1; m_fresh = 0;
            compute(m_a, m_b, m_op);
         end
      end else if (m_age < 3) begin
         m_age++;
      end else if (resp_ready) begin
         m_busy = 0;
         m_cnt = m_cnt + 16'd1;
      end
      @(negedge clk);
   endtask

   task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        output logic [7:0] d, output logic c, output int rid, output int lat);
      int t0;
      bit got;
      d = '0; c = 1'b0; rid = -1; lat = -1; got = 0;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[8*id +: 8] = a; req_b[8*id +: 8] = b; req_op[2*id +: 2] = op;
      resp_ready = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (s_ready[id]) got = 1;
      end
      req_valid = '0;
      if (!got) begin fail_timeout("op_accept"); return; end
      t0 = cyc; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (s_valid) got = 1;
      end
      if (!got) begin fail_timeout("op_resp"); return; end
      d = s_data; c = s_carry; rid = s_id; lat = cyc - t0;
      step();
   endtask

   task automatic drain();
      req_valid = '0;
      resp_ready = 1'b1;
      step();
      for (int k = 0; k < 20 && s_busy; k++) step();
      if (s_busy) fail_timeout("drain");
   endtask

   logic [7:0] d;
   logic       c;
   int         rid, lat;
   int         order[6];
   int         gcyc[6];
   int         gcount;
   bit         got;
   logic [7:0] d0;
   logic       c0;

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      rst = 1'b0;
      step();
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_cnt", 32'(s_cnt), 32'd0);

      // Single ADD from requester 0.
      do_op(0, 8'd200, 8'd100, 2'd0, d, c, rid, lat);
      chk("add_data", 32'(d), 32'd44);
      chk("add_carry", 32'(c), 32'd1);
      chk("add_id", 32'(rid), 32'd0);
      chk("add_latency", 32'(lat), 32'd3);
      chk("add_cnt", 32'(s_cnt), 32'd1);

      // SUB / AND / OR from requester 1.
      do_op(1, 8'd5, 8'd10, 2'd1, d, c, rid, lat);
      chk("sub_data", 32'(d), 32'd251);
      chk("sub_carry", 32'(c), 32'd1);
      chk("sub_id", 32'(rid), 32'd1);
      do_op(1, 8'hF0, 8'h3C, 2'd2, d, c, rid, lat);
      chk("and_data", 32'(d), 32'h30);
      chk("and_carry", 32'(c), 32'd0);
      chk("and_id", 32'(rid), 32'd1);
      do_op(1, 8'hF0, 8'h3C, 2'd3, d, c, rid, lat);
      chk("or_data", 32'(d), 32'hFC);
      chk("or_carry", 32'(c), 32'd0);
      chk("or_id", 32'(rid), 32'd1);

      // Fairness: requesters 0 and 1 both hold valid.
      req_a[7:0] = 8'd17; req_b[7:0] = 8'd3;  req_op[1:0] = 2'd0;
      req_a[15:8] = 8'd9; req_b[15:8] = 8'd20; req_op[3:2] = 2'd1;
      req_valid = 3'b011; resp_ready = 1'b1; gcount = 0;
      for (int k = 0; k < 60 && gcount < 6; k++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (s_ready[i] && gcount < 6) begin
               order[gcount] = i; gcyc[gcount] = cyc; gcount++;
            end
         end
      end
      req_valid = '0;
      chk("fair_count", 32'(gcount), 32'd6);
      for (int j = 0; j < gcount; j++) begin
         chk("fair_order", 32'(order[j]), 32'(j % 2));
         if (j > 0) chk("fair_spacing", 32'(gcyc[j] - gcyc[j-1]), 32'd4);
      end
      drain();

      // Back-pressure with requester 1 waiting.
      req_a[7:0] = 8'd100; req_b[7:0] = 8'd1;
      req_valid = 3'b011; resp_ready = 1'b0; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (s_ready[0]) got = 1;
      end
      if (!got) fail_timeout("bp_accept");
      req_valid[0] = 1'b0; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (s_valid) got = 1;
      end
      if (!got) fail_timeout("bp_resp");
      d0 = s_data; c0 = s_carry;
      chk("bp_id", 32'(s_id), 32'd0);
      chk("bp_data", 32'(d0), 32'd101);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("bp_hold_valid", 32'(s_valid), 32'd1);
         chk("bp_hold_data", 32'(s_data), 32'(d0));
         chk("bp_hold_carry", 32'(s_carry), 32'(c0));
         chk("bp_ready_low", 32'(s_ready), 32'd0);
      end
      resp_ready = 1'b1;
      step();
      chk("bp_hs_ready", 32'(s_ready), 32'd0);
      step();
      chk("bp_next_grant", 32'(s_ready), 32'b010);
      drain();

      // Reset during ISSUE.
      req_valid = 3'b100; req_a[23:16] = 8'd7; req_b[23:16] = 8'd8; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (s_ready[2]) got = 1;
      end
      if (!got) fail_timeout("rst_accept");
      req_valid = '0;
      rst = 1'b1;
      step();
      chk("rst_in_issue", 32'(s_busy), 32'd1);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rst_no_resp", 32'(s_valid), 32'd0);
      end
      chk("rst_alu_a", 32'(s_a), 32'd0);
      chk("rst_cnt_clear", 32'(s_cnt), 32'd0);
      req_valid = 3'b011;
      step();
      chk("rst_first_grant", 32'(s_ready), 32'b001);
      drain();

      // Randomized traffic with occasional reset.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            req_a[8*i +: 8] = 8'($urandom);
            req_b[8*i +: 8] = 8'($urandom);
            req_op[2*i +: 2] = 2'($urandom);
         end
         resp_ready = ($urandom_range(0, 9) < 7);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      drain();

      // Counter wrap from 0xFFFF.
      force dut.done_cnt_q = 16'hFFFF;
      #1;
      release dut.done_cnt_q;
      m_cnt = 16'hFFFF;
      do_op(2, 8'd1, 8'd2, 2'd0, d, c, rid, lat);
      chk("wrap_data", 32'(d), 32'd3);
      chk("wrap_cnt", 32'(s_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
